mux_sel_sequencer: RTL
======================

MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

Interface
REQ-001 The block SHALL have one parameter: DWELL, default 4, the number of cycles sel is held per grant before capture (legal range 1..16).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit: enables starting new grants.
REQ-005 The block SHALL have port req, input, 4 bits: per-channel request, bit i = channel i wants service.
REQ-006 The block SHALL have port mux_out, input, 16 bits: data returned by the downstream 4:1 mux for the current sel.
REQ-007 The block SHALL have port sel, output, 2 bits: channel select driven to the 4:1 mux.
REQ-008 The block SHALL have port gnt, output, 4 bits: one-hot grant of the channel being serviced, 0 when none.
REQ-009 The block SHALL have port data_out, output, 16 bits: captured sample.
REQ-010 The block SHALL have port data_ch, output, 2 bits: channel number of data_out.
REQ-011 The block SHALL have port data_valid, output, 1 bit: single-cycle pulse marking a new data_out/data_ch.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement FSM states IDLE, ARB, HOLD and CAPT.
REQ-014 IDLE SHALL go to ARB when en=1 and req!=0; otherwise it SHALL stay in IDLE.
REQ-015 ARB SHALL pick the first requester searching from (last_ch+1) mod 4 upward with wrap-around, SHALL register sel=channel, gnt=one-hot(channel) and cnt=DWELL-1, and SHALL go to HOLD.
REQ-016 If req==0 when in ARB, the FSM SHALL return to IDLE with sel and gnt unchanged.
REQ-017 HOLD SHALL decrement cnt each cycle and SHALL go to CAPT on the edge where cnt==0, so that HOLD lasts exactly DWELL cycles.
REQ-018 On the edge leaving CAPT, the block SHALL latch mux_out into data_out and sel into data_ch, set data_valid=1 for one cycle, set last_ch=sel and clear gnt.
REQ-019 From CAPT, the FSM SHALL go to ARB if en=1 and req!=0, else to IDLE.
REQ-020 Latency: with req first sampled in IDLE at edge E0, data_valid SHALL be high in the cycle after edge E0+2+DWELL (E0+6 for DWELL=4).
REQ-021 Once a grant is issued, deasserting req or en during HOLD/CAPT SHALL NOT abort it; the capture SHALL still occur.
REQ-022 sel SHALL change only in ARB and SHALL hold its last value in IDLE, HOLD and CAPT.
REQ-023 data_out and data_ch SHALL hold their values between data_valid pulses.
REQ-024 With all four req bits held high, grants SHALL rotate 0,1,2,3,0,...

Reset
REQ-025 Asserting RST_N=0 SHALL immediately, at any time including mid-HOLD, force state=IDLE, sel=0, gnt=0, cnt=0, data_out=0, data_ch=0, data_valid=0, busy=0 and last_ch=3.
REQ-026 After RST_N rises, the first grant SHALL go to the lowest-numbered requester at or above channel 0.
REQ-027 A capture interrupted by reset SHALL be discarded, with no data_valid pulse.

Verification
REQ-028 Scenario: DWELL=4, en=1, req=4'b0100, mux_out=16'hBEEF -> sel=2 and gnt=4'b0100 during HOLD; data_valid pulses once at E0+6 with data_out=16'hBEEF and data_ch=2.
REQ-029 Scenario: req=4'b1111 held, en=1 -> data_ch sequence 0,1,2,3,0, with data_valid pulses spaced DWELL+2 cycles apart.
REQ-030 Scenario: req=4'b1001 after last_ch=0 -> next grant goes to channel 3, then to channel 0 (wrap-around).
REQ-031 Scenario: req dropped to 0 and en=0 mid-HOLD -> capture still completes, then the FSM enters IDLE with busy=0.
REQ-032 Scenario: RST_N pulsed low mid-HOLD -> all outputs zero immediately; no data_valid; the next grant goes to the lowest requester.
REQ-033 Scenario: DWELL=1, req=4'b0001 held -> HOLD lasts one cycle; data_valid at E0+3, then every 3 cycles.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// mux_sel_sequencer
//
// Round-robin sequencer for a downstream 4:1 mux. When enabled and any channel
// requests service, it arbitrates starting just past the last serviced channel,
// drives sel/gnt for that channel, waits DWELL cycles for the mux path to
// settle, then captures mux_out together with the channel number and pulses
// data_valid for one cycle.
//
// Parameters
//   DWELL      cycles sel is held per grant before capture (1..16)
//
// Ports
//   CLK        clock, rising-edge active
//   RST_N      asynchronous active-low reset
//   en         allows new grants to start
//   req[3:0]   per-channel service request
//   mux_out    data returned by the mux for the current sel
//   sel        channel select to the mux
//   gnt        one-hot grant of the channel in service, 0 when none
//   data_out   captured sample
//   data_ch    channel number of data_out
//   data_valid one-cycle pulse marking a new data_out/data_ch
//   busy       high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module mux_sel_sequencer #(
    parameter int unsigned DWELL = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        en,
    input  logic [3:0]  req,
    input  logic [15:0] mux_out,
    output logic [1:0]  sel,
    output logic [3:0]  gnt,
    output logic [15:0] data_out,
    output logic [1:0]  data_ch,
    output logic        data_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        HOLD = 2'd2,
        CAPT = 2'd3
    } state_t;

    // Loaded on grant; HOLD exits on the edge where it reads zero, so HOLD
    // spans exactly DWELL cycles.
    localparam logic [3:0] CNT_INIT = 4'(DWELL - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [1:0] last_ch;
    logic [1:0] pick_ch;
    logic       any_req;

    assign any_req = |req;
    assign busy    = (state != IDLE);

    // Rotating priority: scan from last_ch+4 (lowest priority, i.e. last_ch
    // itself) down to last_ch+1 (highest), so the final hit wins.
    always_comb begin : arbiter
        logic [1:0] cand;
        // NOTE: every variable written here gets a value before any branch,
        // otherwise synthesis infers a latch for the paths that skip it.
        cand    = last_ch;
        pick_ch = last_ch + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            cand = last_ch + 2'(k);
            if (req[cand]) begin
                pick_ch = cand;
            end
        end
    end

    always_comb begin : next_state
        state_nxt = state;
        case (state)
            IDLE: if (en && any_req) state_nxt = ARB;
            ARB:  state_nxt = any_req ? HOLD : IDLE;
            HOLD: if (cnt == 4'd0) state_nxt = CAPT;
            CAPT: state_nxt = (en && any_req) ? ARB : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register in
    // this block samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            sel        <= 2'd0;
            gnt        <= 4'd0;
            cnt        <= 4'd0;
            data_out   <= 16'd0;
            data_ch    <= 2'd0;
            data_valid <= 1'b0;
            // Start one below channel 0 so the first grant searches from 0.
            last_ch    <= 2'd3;
        end else begin
            state      <= state_nxt;
            data_valid <= 1'b0;
            case (state)
                ARB: begin
                    // With no request left, sel/gnt keep their values.
                    if (any_req) begin
                        sel <= pick_ch;
                        gnt <= 4'b0001 << pick_ch;
                        cnt <= CNT_INIT;
                    end
                end
                HOLD: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CAPT: begin
                    // Committed grant: completes even if req/en dropped.
                    data_out   <= mux_out;
                    data_ch    <= sel;
                    data_valid <= 1'b1;
                    last_ch    <= sel;
                    gnt        <= 4'd0;
                end
                default: ;
            endcase
        end
    end

endmodule
